spi_slave_regs: RTL and testbench

SPI mode-0 responder that exposes a 64-entry, 8-bit register space to an external SPI initiator, using the MFRC522 framing: an address byte followed by one or more data bytes per chip-select frame. It sits between the SPI pins and a register-bank or FIFO on the system clock side. It is the bench and loopback counterpart of the team's SPI master, and the front end for any on-chip RC522-style emulation. SCK, CS and MOSI are asynchronous to clk and are synchronised internally.

---
 rtl/spi_slave_pkg.sv | 15 +
 rtl/spi_slave_regs_sync.sv | 33 +++
 rtl/spi_slave_regs.sv | 140 ++++++++++++++
 tb/tb_spi_slave_regs.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI register-space responder.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  // Address byte layout: {rw, addr[5:0], unused}
  localparam int RW_BIT     = 7;
  localparam int ADDR_LSB   = 1;
  localparam int REG_ADDR_W = 6;

endpackage

// File: rtl/spi_slave_regs_sync.sv
// Single-pin synchroniser with edge detection: SYNC_STAGES flop chain plus a
// previous-value flop. Everything resets to 0 so that a reset taken while CS
// is held low never fabricates a CS fall; the rest of that frame is ignored.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain and one-cycle-delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder exposing a 64 x 8-bit register space with MFRC522
// framing (address byte then data bytes per CS frame).
// Optional feature macro: SPI_SLAVE_AUTOINC_EN -- when defined, reg_addr
// advances (mod 64) after every reg_wr/reg_rd; otherwise it stays fixed for
// the whole frame (FIFO-style repeated access).
module spi_slave_regs
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_lvl;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        rx_q, tx_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q, wr_q, rd_q, load_q, ferr_q;
  logic [7:0]        rx_byte;
  logic              byte_done;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .rst(rst), .pin_i(sck),
    .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .pin_i(cs),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // MOSI only needs a level, aligned with the SCK edge detector latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];

  assign rx_byte   = {rx_q[6:0], mosi_lvl};
  assign byte_done = sck_rise && !cs_lvl && (state_q != IDLE) && (bit_cnt_q == 3'd7);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: frame start on CS fall, address byte then data bytes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ADDR;
      ADDR:    if (byte_done) state_d = DATA;
      DATA:    state_d = DATA;
      default: state_d = IDLE;
    endcase
    if (cs_lvl) state_d = IDLE;
  end

  // Shift registers, bit counter, register-side strobes and address tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= 3'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'h00;
      wdata_q   <= 8'h00;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      load_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      ferr_q <= 1'b0;
      load_q <= rd_q;
      if (cs_rise && (state_q != IDLE) && (bit_cnt_q != 3'd0)) ferr_q <= 1'b1;
`ifdef SPI_SLAVE_AUTOINC_EN
      if (wr_q || rd_q) addr_q <= addr_q + ADDR_ONE;
`endif
      if (cs_lvl || (state_q == IDLE)) begin
        bit_cnt_q <= 3'd0;
        rx_q      <= 8'h00;
        tx_q      <= 8'h00;
      end else begin
        if (sck_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          rx_q      <= rx_byte;
          if (byte_done) begin
            if (state_q == ADDR) begin
              rw_q   <= rx_byte[RW_BIT];
              addr_q <= rx_byte[RW_BIT-1:ADDR_LSB];
              rd_q   <= rx_byte[RW_BIT];
            end else if (rw_q) begin
              rd_q <= 1'b1;
            end else begin
              wdata_q <= rx_byte;
              wr_q    <= 1'b1;
            end
          end
        end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
          // The fall that closes a byte does not shift: it exposes the MSB
          // of the freshly loaded read data instead.
          tx_q <= {tx_q[6:0], 1'b0};
        end
        if (load_q) tx_q <= reg_rdata;
      end
    end
  end

  assign miso      = tx_q[7];
  assign miso_oe   = (state_q != IDLE);
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr    = wr_q;
  assign reg_rd    = rd_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed + randomized bench for spi_slave_regs with a frame-level model.
module tb_spi_slave_regs;

`ifdef SPI_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b0, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic       miso, miso_oe, reg_wr, reg_rd, frame_err;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  bank    [64];
  logic [7:0]  ref_mem [64];
  logic [13:0] wr_log [$];
  logic [5:0]  rd_log [$];
  int          ferr_cnt = 0, both_cnt = 0, idle_cnt = 0;
  logic [7:0]  fb  [$];
  logic [7:0]  rxb [$];

  spi_slave_regs #(.SYNC_STAGES(2), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register bank on the system side: registered read, data one clk after reg_rd
  always @(posedge clk) begin
    if (reg_wr) bank[reg_addr] = reg_wdata;
    if (reg_rd) reg_rdata <= bank[reg_addr];
  end

  // Strobe logger, sampled away from the active edge
  always @(negedge clk) begin
    if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_log.push_back(reg_addr);
    if (frame_err) ferr_cnt++;
    if (reg_wr && reg_rd) both_cnt++;
    if ((reg_wr || reg_rd) && !miso_oe) idle_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},      32'(miso),      32'd0);
    check({tag, "_miso_oe"},   32'(miso_oe),   32'd0);
    check({tag, "_reg_addr"},  32'(reg_addr),  32'd0);
    check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, "_reg_wr"},    32'(reg_wr),    32'd0);
    check({tag, "_reg_rd"},    32'(reg_rd),    32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // One byte, MSB first, SCK phases of 4 clk; MISO captured at each rise
  task automatic xfer_byte(input logic [7:0] b, input int nbits, input int rst_bit,
                           output logic [7:0] r);
    r = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      mosi = b[7-k];
      if (k == rst_bit) begin
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      r = {r[6:0], miso};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  // Drive the frame in fb and compare against the frame-level model
  task automatic run_frame(input string tag, input int abort_bits, input int rst_bit);
    int          wb, rb, fbase, nc, nb;
    logic [7:0]  r;
    logic        rw;
    logic [5:0]  a;
    logic [13:0] exp_wr [$];
    logic [5:0]  exp_rd [$];
    logic [7:0]  exp_miso [$];
    wb = wr_log.size(); rb = rd_log.size(); fbase = ferr_cnt;
    rxb.delete();
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < fb.size(); i++) begin
      nb = (i == fb.size() - 1 && abort_bits > 0) ? abort_bits : 8;
      xfer_byte(fb[i], nb, (i == 0) ? rst_bit : -1, r);
      rxb.push_back(r);
    end
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);

    nc = (abort_bits > 0) ? fb.size() - 1 : fb.size();
    if (rst_bit >= 0) nc = 0;
    rw = fb[0][7];
    a  = fb[0][6:1];
    if (nc > 0) exp_miso.push_back(8'h00);
    for (int i = 1; i < nc; i++) begin
      if (rw) begin
        exp_rd.push_back(a);
        exp_miso.push_back(ref_mem[a]);
      end else begin
        exp_wr.push_back({a, fb[i]});
        ref_mem[a] = fb[i];
        exp_miso.push_back(8'h00);
      end
      if (AUTOINC) a = a + 6'd1;
    end
    if (rw && nc > 0) exp_rd.push_back(a);

    check({tag, "_wr_count"}, 32'(wr_log.size() - wb), 32'(exp_wr.size()));
    check({tag, "_rd_count"}, 32'(rd_log.size() - rb), 32'(exp_rd.size()));
    check({tag, "_frame_err"}, 32'(ferr_cnt - fbase), 32'((abort_bits > 0 && rst_bit < 0) ? 1 : 0));
    for (int i = 0; i < exp_wr.size(); i++)
      if (wb + i < wr_log.size())
        check($sformatf("%s_wr%0d", tag, i), 32'(wr_log[wb+i]), 32'(exp_wr[i]));
    for (int i = 0; i < exp_rd.size(); i++)
      if (rb + i < rd_log.size())
        check($sformatf("%s_rd%0d", tag, i), 32'(rd_log[rb+i]), 32'(exp_rd[i]));
    for (int i = 0; i < exp_miso.size(); i++)
      check($sformatf("%s_miso%0d", tag, i), 32'(rxb[i]), 32'(exp_miso[i]));
  endtask

  initial begin
    logic [7:0] v;
    int         n;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      bank[i] = v;
      ref_mem[i] = v;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Single write to 0x0A
    fb = '{8'h14, 8'hA5};
    run_frame("wr_single", 0, -1);
    check("wr_single_bank", 32'(bank[10]), 32'h0000_00A5);

    // Single read of 0x0A returning 0x3C
    bank[10] = 8'h3C; ref_mem[10] = 8'h3C;
    fb = '{8'h94, 8'h00};
    run_frame("rd_single", 0, -1);

    // Burst write at the top of the address space
    fb = '{8'h7E, 8'h11, 8'h22, 8'h33};
    run_frame("wr_burst", 0, -1);

    // Burst read crossing the wrap point when auto-increment is enabled
    fb = '{8'hFC, 8'h00, 8'h00, 8'h00};
    run_frame("rd_burst", 0, -1);

    // Abort after 5 bits of a data byte, then a normal frame
    fb = '{8'h28, 8'h99};
    run_frame("abort", 5, -1);
    fb = '{8'h28, 8'h5A};
    run_frame("post_abort", 0, -1);

    // Reset during the 3rd bit of the address byte, then a normal frame
    fb = '{8'h14, 8'h55};
    run_frame("rst_frame", 0, 2);
    fb = '{8'h96, 8'h00};
    run_frame("post_rst", 0, -1);

    // Randomized back-to-back frames
    for (int f = 0; f < 8; f++) begin
      fb.delete();
      v = {1'($urandom_range(0, 1)), 6'($urandom), 1'b0};
      fb.push_back(v);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) fb.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), 0, -1);
    end

    check("no_wr_rd_overlap", 32'(both_cnt), 32'd0);
    check("no_strobe_in_idle", 32'(idle_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
